vga_timing_gen: RTL and testbench

//  Parametrised raster timing generator; successor to the fixed 640x480 sync counter.

---
 rtl/vga_timing_gen_pkg.sv | 24 ++
 rtl/vga_timing_gen_if.sv | 21 ++
 rtl/vga_pipe_delay.sv | 48 ++++
 rtl/vga_timing_gen.sv | 123 ++++++++++++
 tb/tb_vga_timing_gen.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_gen_pkg.sv
// Shared constants for the raster timing generator: default 640x480@60 geometry,
// sync polarity encodings and a small window helper.
package vga_timing_gen_pkg;

    localparam int DEF_H_DISPLAY = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_DISPLAY = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;
    localparam int DEF_CNT_W     = 10;

    localparam bit POL_ACTIVE_LOW  = 1'b0;
    localparam bit POL_ACTIVE_HIGH = 1'b1;

    localparam int MAX_LATENCY = 8;

    function automatic logic in_window(input int pos, input int start, input int width);
        return (pos >= start) && (pos < start + width);
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Video timing bundle: the generator drives it (master), the renderer consumes it (slave).
interface vga_timing_gen_if #(
    parameter int CNT_W = 10
);
    logic             hsync;
    logic             vsync;
    logic             display_en;
    logic [CNT_W-1:0] pix_x;
    logic [CNT_W-1:0] pix_y;
    logic             frame_start;
    logic             line_end;
    logic             update;

    modport master (
        output hsync, vsync, display_en, pix_x, pix_y, frame_start, line_end, update
    );

    modport slave (
        input hsync, vsync, display_en, pix_x, pix_y, frame_start, line_end, update
    );
endinterface

// File: rtl/vga_pipe_delay.sv
// Enable-gated shift register: DEPTH stages, each advancing only when en is high,
// with asynchronous active-low reset to RESET_VAL.
module vga_pipe_delay #(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    if (DEPTH < 1) begin : g_bad_depth
        $error("vga_pipe_delay: DEPTH must be at least 1");
    end

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i];
        end
        if (en) begin
            stage_d[0] = din;
            for (int i = 1; i < DEPTH; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= RESET_VAL;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: H/V counters advanced by the pixel enable,
// sync/display/strobe decode, and an optional pipeline to align with pixel-data stages.
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int H_DISPLAY = DEF_H_DISPLAY,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_DISPLAY = DEF_V_DISPLAY,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK,
    parameter bit H_POL     = POL_ACTIVE_LOW,
    parameter bit V_POL     = POL_ACTIVE_LOW,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int LATENCY   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_pixel,
    vga_timing_gen_if.master  vid
);

    localparam int H_TOTAL      = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL      = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int H_SYNC_START = H_DISPLAY + H_FRONT;
    localparam int V_SYNC_START = V_DISPLAY + V_FRONT;
    localparam int PIPE_W       = 2 * CNT_W + 6;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_UPDATE = CNT_W'(V_DISPLAY);

    // Reset image of the pipeline: syncs inactive, everything else zero.
    localparam logic [PIPE_W-1:0] PIPE_RST = {~H_POL, ~V_POL, {(PIPE_W-2){1'b0}}};

    if ((H_TOTAL - 1) >= (2 ** CNT_W) || (V_TOTAL - 1) >= (2 ** CNT_W)) begin : g_bad_cnt_w
        $error("vga_timing_gen: CNT_W too small for H_TOTAL/V_TOTAL");
    end
    if (H_SYNC < 1 || V_SYNC < 1) begin : g_bad_sync
        $error("vga_timing_gen: sync widths must be at least 1");
    end
    if (LATENCY < 0 || LATENCY > MAX_LATENCY) begin : g_bad_latency
        $error("vga_timing_gen: LATENCY must be in 0..8");
    end

    logic [CNT_W-1:0] h_q, h_d;
    logic [CNT_W-1:0] v_q, v_d;
    logic             en_q, en_d;

    always_comb begin
        h_d = h_q;
        v_d = v_q;
        en_d = clk_pixel;
        if (clk_pixel) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_q  <= '0;
            v_q  <= '0;
            en_q <= 1'b0;
        end else begin
            h_q  <= h_d;
            v_q  <= v_d;
            en_q <= en_d;
        end
    end

    logic hs_raw, vs_raw, de_raw, fs_req, le_req, up_req;

    always_comb begin
        hs_raw = in_window(int'(h_q), H_SYNC_START, H_SYNC) ? H_POL : ~H_POL;
        vs_raw = in_window(int'(v_q), V_SYNC_START, V_SYNC) ? V_POL : ~V_POL;
        de_raw = (int'(h_q) < H_DISPLAY) && (int'(v_q) < V_DISPLAY);
        fs_req = (h_q == '0) && (v_q == '0);
        le_req = (h_q == H_LAST);
        up_req = (h_q == '0) && (v_q == V_UPDATE);
    end

    logic [PIPE_W-1:0] pipe_in, pipe_out;

    assign pipe_in = {hs_raw, vs_raw, de_raw, h_q, v_q, fs_req, le_req, up_req};

    // The first stage is the output register itself, so depth is LATENCY+1.
    vga_pipe_delay #(
        .WIDTH     (PIPE_W),
        .DEPTH     (LATENCY + 1),
        .RESET_VAL (PIPE_RST)
    ) u_pipe (
        .clk  (clk),
        .rst  (rst),
        .en   (clk_pixel),
        .din  (pipe_in),
        .dout (pipe_out)
    );

    logic             hs_o, vs_o, de_o, fs_o, le_o, up_o;
    logic [CNT_W-1:0] x_o, y_o;

    assign {hs_o, vs_o, de_o, x_o, y_o, fs_o, le_o, up_o} = pipe_out;

    assign vid.hsync      = hs_o;
    assign vid.vsync      = vs_o;
    assign vid.display_en = de_o;
    assign vid.pix_x      = x_o;
    assign vid.pix_y      = y_o;

    // Strobe requests persist in the pipe between enables; en_q trims them to the single
    // clk that follows the enable edge which loaded them.
    assign vid.frame_start = fs_o & en_q;
    assign vid.line_end    = le_o & en_q;
    assign vid.update      = up_o & en_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: a behavioural raster model pushes expected output tuples per enable,
// popped after each DUT's pipeline latency and compared every clock.
module tb_vga_timing_gen;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       de;
        logic [9:0] x;
        logic [9:0] y;
        logic       fs;
        logic       le;
        logic       up;
    } exp_t;

    logic clk;
    logic rst_ab, rst_c;
    logic en_ab, en_c;

    int n_vec  = 0;
    int n_miss = 0;

    vga_timing_gen_if #(.CNT_W(10)) vid_a ();
    vga_timing_gen_if #(.CNT_W(10)) vid_b ();
    vga_timing_gen_if #(.CNT_W(10)) vid_c ();

    vga_timing_gen #(.LATENCY(0)) dut_a (
        .clk(clk), .rst(rst_ab), .clk_pixel(en_ab), .vid(vid_a)
    );

    vga_timing_gen #(.LATENCY(2)) dut_b (
        .clk(clk), .rst(rst_ab), .clk_pixel(en_ab), .vid(vid_b)
    );

    vga_timing_gen #(
        .H_DISPLAY(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_DISPLAY(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .H_POL(1'b1), .V_POL(1'b1), .CNT_W(10), .LATENCY(0)
    ) dut_c (
        .clk(clk), .rst(rst_c), .clk_pixel(en_c), .vid(vid_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic exp_t model(input int h, input int v,
                                   input int hd, input int hf, input int hsw, input int hb,
                                   input int vd, input int vf, input int vsw, input int vb,
                                   input bit hp, input bit vp);
        exp_t e;
        e.hs = (h >= hd + hf && h < hd + hf + hsw) ? hp : ~hp;
        e.vs = (v >= vd + vf && v < vd + vf + vsw) ? vp : ~vp;
        e.de = (h < hd) && (v < vd);
        e.x  = 10'(h);
        e.y  = 10'(v);
        e.fs = (h == 0) && (v == 0);
        e.le = (h == hd + hf + hsw + hb - 1);
        e.up = (h == 0) && (v == vd);
        return e;
    endfunction

    function automatic exp_t reset_tuple(input bit hp, input bit vp);
        exp_t e;
        e = '0;
        e.hs = ~hp;
        e.vs = ~vp;
        return e;
    endfunction

    function automatic exp_t pack(input logic hs, input logic vs, input logic de,
                                  input logic [9:0] x, input logic [9:0] y,
                                  input logic fs, input logic le, input logic up);
        exp_t e;
        e = {hs, vs, de, x, y, fs, le, up};
        return e;
    endfunction

    exp_t sbq [3][$];
    exp_t cur [3];
    bit   popped [3];
    int   mh [3];
    int   mv [3];

    task automatic sb_step(input int k, input logic rstv, input logic en, input int lat,
                           input int hd, input int hf, input int hsw, input int hb,
                           input int vd, input int vf, input int vsw, input int vb,
                           input bit hp, input bit vp);
        int htot, vtot;
        htot = hd + hf + hsw + hb;
        vtot = vd + vf + vsw + vb;
        popped[k] = 1'b0;
        if (!rstv) begin
            sbq[k].delete();
            mh[k]  = 0;
            mv[k]  = 0;
            cur[k] = reset_tuple(hp, vp);
        end else if (en) begin
            sbq[k].push_back(model(mh[k], mv[k], hd, hf, hsw, hb, vd, vf, vsw, vb, hp, vp));
            if (mh[k] == htot - 1) begin
                mh[k] = 0;
                mv[k] = (mv[k] == vtot - 1) ? 0 : mv[k] + 1;
            end else begin
                mh[k] = mh[k] + 1;
            end
            if (sbq[k].size() > lat) begin
                cur[k]    = sbq[k].pop_front();
                popped[k] = 1'b1;
            end
        end
    endtask

    function automatic exp_t expected(input int k);
        exp_t e;
        e = cur[k];
        if (!popped[k]) begin
            e.fs = 1'b0;
            e.le = 1'b0;
            e.up = 1'b0;
        end
        return e;
    endfunction

    int a_en_idx    = 0;
    int a_last_fall = -1;
    bit a_prev_hs   = 1'b1;
    int c_clk       = 0;
    int c_last_fs   = -1;
    int c_last_le   = -1;

    always @(posedge clk) begin
        logic ab_live, ab_en, c_live;
        ab_live = rst_ab;
        ab_en   = en_ab;
        c_live  = rst_c;
        sb_step(0, rst_ab, en_ab, 0, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0);
        sb_step(1, rst_ab, en_ab, 2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0);
        sb_step(2, rst_c,  en_c,  0, 4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1);
        c_clk++;
        #1;
        checkOutput("sb_a", 64'(pack(vid_a.hsync, vid_a.vsync, vid_a.display_en, vid_a.pix_x,
                    vid_a.pix_y, vid_a.frame_start, vid_a.line_end, vid_a.update)), 64'(expected(0)));
        checkOutput("sb_b", 64'(pack(vid_b.hsync, vid_b.vsync, vid_b.display_en, vid_b.pix_x,
                    vid_b.pix_y, vid_b.frame_start, vid_b.line_end, vid_b.update)), 64'(expected(1)));
        checkOutput("sb_c", 64'(pack(vid_c.hsync, vid_c.vsync, vid_c.display_en, vid_c.pix_x,
                    vid_c.pix_y, vid_c.frame_start, vid_c.line_end, vid_c.update)), 64'(expected(2)));

        // hsync geometry on the default-timing instance, measured in enables
        if (!ab_live) begin
            a_en_idx    = 0;
            a_last_fall = -1;
            a_prev_hs   = 1'b1;
        end else if (ab_en) begin
            a_en_idx++;
            if (a_prev_hs && !vid_a.hsync) begin
                checkOutput("hs_fall_x", 64'(vid_a.pix_x), 64'(656));
                if (a_last_fall >= 0)
                    checkOutput("hs_period", 64'(a_en_idx - a_last_fall), 64'(800));
                a_last_fall = a_en_idx;
            end else if (!a_prev_hs && vid_a.hsync && a_last_fall >= 0) begin
                checkOutput("hs_low_width", 64'(a_en_idx - a_last_fall), 64'(96));
            end
            a_prev_hs = vid_a.hsync;
        end

        // frame and line strobe spacing on the small-geometry instance, measured in clocks
        if (!c_live) begin
            c_last_fs = -1;
            c_last_le = -1;
        end else begin
            if (vid_c.frame_start) begin
                if (c_last_fs >= 0)
                    checkOutput("c_frame_len", 64'(c_clk - c_last_fs), 64'(48));
                c_last_fs = c_clk;
            end
            if (vid_c.line_end) begin
                if (c_last_le >= 0)
                    checkOutput("c_line_len", 64'(c_clk - c_last_le), 64'(8));
                c_last_le = c_clk;
            end
        end
    end

    task automatic applyStimulus(input int n_clk, input int period);
        for (int i = 0; i < n_clk; i++) begin
            @(negedge clk);
            en_ab = (period > 0) && ((i % period) == (period - 1));
        end
    endtask

    task automatic check_reset_all(input string suffix);
        checkOutput({"rst_a", suffix}, 64'(pack(vid_a.hsync, vid_a.vsync, vid_a.display_en,
                    vid_a.pix_x, vid_a.pix_y, vid_a.frame_start, vid_a.line_end, vid_a.update)),
                    64'(reset_tuple(1'b0, 1'b0)));
        checkOutput({"rst_b", suffix}, 64'(pack(vid_b.hsync, vid_b.vsync, vid_b.display_en,
                    vid_b.pix_x, vid_b.pix_y, vid_b.frame_start, vid_b.line_end, vid_b.update)),
                    64'(reset_tuple(1'b0, 1'b0)));
        checkOutput({"rst_c", suffix}, 64'(pack(vid_c.hsync, vid_c.vsync, vid_c.display_en,
                    vid_c.pix_x, vid_c.pix_y, vid_c.frame_start, vid_c.line_end, vid_c.update)),
                    64'(reset_tuple(1'b1, 1'b1)));
    endtask

    initial begin
        rst_ab = 1'b1;
        rst_c  = 1'b1;
        en_ab  = 1'b0;
        en_c   = 1'b0;
        #2;
        rst_ab = 1'b0;
        rst_c  = 1'b0;
        #1;
        check_reset_all("_power_on");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_ab = 1'b1;
        rst_c  = 1'b1;
        en_c   = 1'b1;

        $display("[TB] default timing, enable every 4th clk");
        applyStimulus(1700 * 4, 4);

        $display("[TB] enable held low for 50 clk mid-line");
        applyStimulus(50, 0);
        applyStimulus(400, 4);

        $display("[TB] asynchronous reset mid-frame");
        @(negedge clk);
        en_ab = 1'b0;
        #2;
        rst_ab = 1'b0;
        rst_c  = 1'b0;
        #1;
        check_reset_all("_async");
        repeat (3) @(posedge clk);
        #3;
        rst_ab = 1'b1;
        rst_c  = 1'b1;
        applyStimulus(200, 4);

        $display("[TB] default timing, enable held high");
        applyStimulus(900, 1);
        applyStimulus(10, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
